// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem request, skid buffer and IF/ID register.
// Obeys load-use stall enables and EX-stage redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_we,
    input  logic        id_reg_we,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_next,
    output logic [31:0] if_id_inst
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INST_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_d;
    logic [3:0]      rmask_d;
    logic            if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_d, if_id_pc_next_d, if_id_inst_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_inst_q, skid_inst_d;

    logic            adv;
    logic            req_live;
    logic [XLEN-1:0] target;

    assign adv      = pc_we & id_reg_we;
    // rmask is low only in the first cycle after reset and in S_HOLD
    assign req_live = (imem_rmask == 4'hF);
    assign target   = {branch_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            imem_addr     <= RESET_PC;
            imem_rmask    <= 4'h0;
            if_id_valid   <= 1'b0;
            if_id_pc      <= '0;
            if_id_pc_next <= '0;
            if_id_inst    <= '0;
            skid_pc_q     <= '0;
            skid_inst_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_addr     <= addr_d;
            imem_rmask    <= rmask_d;
            if_id_valid   <= if_id_valid_d;
            if_id_pc      <= if_id_pc_d;
            if_id_pc_next <= if_id_pc_next_d;
            if_id_inst    <= if_id_inst_d;
            skid_pc_q     <= skid_pc_d;
            skid_inst_q   <= skid_inst_d;
        end
    end

    // Next-state, PC, request and IF/ID update logic
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = imem_addr;
        rmask_d         = imem_rmask;
        if_id_valid_d   = if_id_valid;
        if_id_pc_d      = if_id_pc;
        if_id_pc_next_d = if_id_pc_next;
        if_id_inst_d    = if_id_inst;
        skid_pc_d       = skid_pc_q;
        skid_inst_d     = skid_inst_q;

        // Bubble unless an instruction is delivered below; id_reg_we=0 holds everything
        if (flush || id_reg_we) begin
            if_id_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                if (!req_live) begin
                    rmask_d = 4'hF;
                    if (flush) begin
                        pc_d   = target;
                        addr_d = target;
                    end
                end else if (imem_resp) begin
                    if (flush) begin
                        pc_d   = target;
                        addr_d = target;
                    end else if (adv) begin
                        if_id_valid_d   = 1'b1;
                        if_id_pc_d      = pc_q;
                        if_id_pc_next_d = pc_q + INST_BYTES;
                        if_id_inst_d    = imem_rdata;
                        pc_d            = pc_q + INST_BYTES;
                        addr_d          = pc_q + INST_BYTES;
                    end else begin
                        skid_pc_d   = pc_q;
                        skid_inst_d = imem_rdata;
                        rmask_d     = 4'h0;
                        state_d     = S_HOLD;
                    end
                end else if (flush) begin
                    // imem_addr keeps the squashed address until its response
                    pc_d    = target;
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d    = target;
                    addr_d  = target;
                    rmask_d = 4'hF;
                    state_d = S_REQ;
                end else if (adv) begin
                    if_id_valid_d   = 1'b1;
                    if_id_pc_d      = skid_pc_q;
                    if_id_pc_next_d = skid_pc_q + INST_BYTES;
                    if_id_inst_d    = skid_inst_q;
                    pc_d            = pc_q + INST_BYTES;
                    addr_d          = pc_q + INST_BYTES;
                    rmask_d         = 4'hF;
                    state_d         = S_REQ;
                end
            end
            S_DROP: begin
                if (flush) begin
                    pc_d = target;
                end
                if (imem_resp) begin
                    addr_d  = flush ? target : pc_q;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a memory model answers requests with
// address-derived data, and the delivered stream is checked against program order.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic        clk;
    logic        rst_n;
    logic        pc_we;
    logic        id_reg_we;
    logic        flush;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_next;
    logic [31:0] if_id_inst;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;

    // Program-order PCs still expected in IF/ID; a redirect replaces the stream
    logic [31:0] exp_q[$];

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_we        (pc_we),
        .id_reg_we    (id_reg_we),
        .flush        (flush),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rmask   (imem_rmask),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_pc_next(if_id_pc_next),
        .if_id_inst   (if_id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h00000013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model state (driver-owned)
    logic        busy;
    logic [31:0] req_addr;
    int          lat;

    task automatic apply_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_rmask", 32'(imem_rmask), 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_pc_next", if_id_pc_next, 32'h0);
        check("rst_inst", if_id_inst, 32'h0);
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        busy      = 1'b0;
        imem_resp = 1'b0;
        flush     = 1'b0;
        repeat (2) @(negedge clk);
        // Stray response right at release must never reach IF/ID
        rst_n      = 1'b1;
        imem_resp  = 1'b1;
        imem_rdata = 32'hdeadbeef;
        pc_we      = 1'b1;
        id_reg_we  = 1'b1;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 4))
            0:       return 32'h1eceb100;
            1:       return 32'h1eceb200 | 32'($urandom_range(0, 3));
            2:       return 32'hfffffff8 | 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    // Driver: pipeline enables, redirects and the instruction memory
    initial begin
        rst_n         = 1'b0;
        pc_we         = 1'b0;
        id_reg_we     = 1'b0;
        flush         = 1'b0;
        branch_target = '0;
        imem_rdata    = '0;
        imem_resp     = 1'b0;
        busy          = 1'b0;
        req_addr      = '0;
        lat           = 0;
        exp_q.push_back(RESET_PC);
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) apply_reset();
            @(negedge clk);
            if (c < 20 || (c >= 2000 && c < 2020)) begin
                pc_we     = 1'b1;
                id_reg_we = 1'b1;
                flush     = 1'b0;
            end else begin
                pc_we     = ($urandom_range(0, 9) != 0);
                id_reg_we = ($urandom_range(0, 9) != 0);
                flush     = ($urandom_range(0, 15) == 0);
            end
            if (flush) begin
                branch_target = pick_target();
                exp_q.delete();
                exp_q.push_back({branch_target[31:2], 2'b00});
            end
            if (imem_rmask == 4'hF) begin
                if (!busy) begin
                    busy     = 1'b1;
                    req_addr = imem_addr;
                    lat      = (c < 20) ? 0 : $urandom_range(0, 3);
                    check("addr_align", 32'(imem_addr[1:0]), 32'h0);
                end else begin
                    check("addr_stable", imem_addr, req_addr);
                end
                if (lat == 0) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_word(req_addr);
                    busy       = 1'b0;
                end else begin
                    lat--;
                    imem_resp  = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                check("rmask_value", 32'(imem_rmask), 32'h0);
                check("rmask_early_drop", 32'(busy), 32'h0);
                busy       = 1'b0;
                imem_resp  = 1'b0;
                imem_rdata = $urandom;
            end
        end
        @(negedge clk);
        pc_we     = 1'b0;
        id_reg_we = 1'b0;
        flush     = 1'b0;
        imem_resp = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_deliv < 500) begin
            errors++;
            $display("FAIL deliveries actual=%0d required>=500", n_deliv);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: sample the edge's controls, then check IF/ID just after it
    logic        last_valid = 1'b0;
    logic [31:0] last_pc = '0;
    always begin
        logic        s_rst, s_flush, s_id, s_pcwe;
        logic [31:0] exp;
        @(posedge clk);
        s_rst   = rst_n;
        s_flush = flush;
        s_id    = id_reg_we;
        s_pcwe  = pc_we;
        #1;
        if (s_rst && rst_n) begin
            if (s_flush) begin
                check("flush_bubble", 32'(if_id_valid), 32'h0);
            end else if (!s_id) begin
                check("hold_valid", 32'(if_id_valid), 32'(last_valid));
                check("hold_pc", if_id_pc, last_pc);
            end else if (!s_pcwe) begin
                check("stall_bubble", 32'(if_id_valid), 32'h0);
            end else if (if_id_valid) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual_pc=%h required=none", if_id_pc);
                end else begin
                    exp = exp_q.pop_front();
                    exp_q.push_back(exp + 32'd4);
                    check("ifid_pc", if_id_pc, exp);
                    check("ifid_pc_next", if_id_pc_next, exp + 32'd4);
                    check("ifid_inst", if_id_inst, mem_word(exp));
                end
            end
        end
        last_valid = if_id_valid;
        last_pc    = if_id_pc;
    end

endmodule
